// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, 8N1 frame constants and bit-period helper.
// Used by both the transmit and receive paths.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_e;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;

   function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                     input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// CPU-side push/status port of the UART transmitter.
interface uart_tx_if;

   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       busy;
   logic       overflow;

   modport master (
      output wr_en,
      output wr_data,
      input  full,
      input  busy,
      input  overflow
   );

   modport slave (
      input  wr_en,
      input  wr_data,
      output full,
      output busy,
      output overflow
   );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous DEPTH x 8 first-word-fall-through FIFO feeding the transmitter.
// A push while full is dropped and flagged by a one-cycle overflow pulse.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty,
   output logic       overflow
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CNTW = PW + 1;

   logic [7:0]      mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CNTW-1:0] count;
   logic [CNTW-1:0] count_n;
   logic            push_ok;
   logic            pop_ok;

   // Rejection looks at the registered full flag, so a same-cycle pop never rescues a push.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_n = count;
      case ({push_ok, pop_ok})
         2'b10:   count_n = count + 1'b1;
         2'b01:   count_n = count - 1'b1;
         default: count_n = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count    <= count_n;
         full     <= (count_n == CNTW'(DEPTH));
         empty    <= (count_n == '0);
         overflow <= push & full;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: drains an internal FIFO onto the tx line, LSB first,
// with back-to-back frames when more bytes are queued.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned BAUD   = 9600,
   parameter int unsigned DEPTH  = 4
) (
   input  logic      clk,
   input  logic      reset,
   uart_tx_if.slave  bus,
   output logic      tx
);

   localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
   localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    DATA_LAST  = 3'(DATA_BITS - 1);
   localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);

   uart_state_e   state;
   uart_state_e   state_n;
   logic [CW-1:0] baud_cnt;
   logic [CW-1:0] baud_n;
   logic [7:0]    shift;
   logic [7:0]    shift_n;
   logic [2:0]    idx;
   logic [2:0]    idx_n;
   logic          bit_end;
   logic          pop;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;

   uart_tx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (bus.wr_en),
      .pop      (pop),
      .din      (bus.wr_data),
      .dout     (fifo_dout),
      .full     (bus.full),
      .empty    (fifo_empty),
      .overflow (bus.overflow)
   );

   assign bit_end  = (baud_cnt == BAUD_LAST);
   assign bus.busy = (state != IDLE) | ~fifo_empty;

   always_comb begin
      state_n = state;
      baud_n  = bit_end ? '0 : baud_cnt + 1'b1;
      shift_n = shift;
      idx_n   = idx;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            baud_n = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_n = fifo_dout;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               idx_n   = '0;
               state_n = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_n = {1'b0, shift[7:1]};
               idx_n   = idx + 1'b1;
               if (idx == DATA_LAST) begin
                  idx_n   = '0;
                  state_n = STOP;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               idx_n = idx + 1'b1;
               if (idx == STOP_LAST) begin
                  idx_n = '0;
                  if (!fifo_empty) begin
                     pop     = 1'b1;
                     shift_n = fifo_dout;
                     state_n = START;
                  end else begin
                     state_n = IDLE;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         shift    <= '0;
         idx      <= '0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         shift    <= shift_n;
         idx      <= idx_n;
      end
   end

   // Line level is registered from the current state, so tx trails the FSM by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx <= 1'b1;
      end else begin
         case (state)
            START:   tx <= 1'b0;
            DATA:    tx <= shift[0];
            default: tx <= 1'b1;
         endcase
      end
   end

endmodule
